// File: rtl/vga_pkg.sv
// Shared constants and types for the text terminal tile-buffer controller.
package vga_pkg;

   localparam int unsigned H_TILES        = 160;
   localparam int unsigned V_TILES        = 64;
   localparam int unsigned ADDR_COL_WIDTH = 8;
   localparam int unsigned ADDR_ROW_WIDTH = 6;
   localparam int unsigned DATA_WIDTH     = 7;

   localparam logic [DATA_WIDTH-1:0] CHAR_NUL   = 7'h00;
   localparam logic [DATA_WIDTH-1:0] CHAR_BS    = 7'h08;
   localparam logic [DATA_WIDTH-1:0] CHAR_LF    = 7'h0A;
   localparam logic [DATA_WIDTH-1:0] CHAR_CR    = 7'h0D;
   localparam logic [DATA_WIDTH-1:0] CHAR_FIRST = 7'h20;
   localparam logic [DATA_WIDTH-1:0] CHAR_LAST  = 7'h7E;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } term_state_e;

   typedef enum logic [2:0] {
      CUR_HOLD = 3'd0,
      CUR_INC  = 3'd1,
      CUR_NL   = 3'd2,
      CUR_CR   = 3'd3,
      CUR_DEC  = 3'd4,
      CUR_HOME = 3'd5
   } cur_op_e;

endpackage

// File: rtl/tile_cursor.sv
// Column/row position counter with screen wrap; used for the text cursor and the clear sweep.
module tile_cursor
   import vga_pkg::*;
#(
   parameter int unsigned COLS  = H_TILES,
   parameter int unsigned ROWS  = V_TILES,
   parameter int unsigned COL_W = ADDR_COL_WIDTH,
   parameter int unsigned ROW_W = ADDR_ROW_WIDTH
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  cur_op_e          op_i,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [COL_W-1:0] col_d;
   logic [ROW_W-1:0] row_d;
   logic [ROW_W-1:0] row_next;

   // Next position for each operation; the bottom row wraps to the top (no scroll)
   always_comb begin
      row_next = (row_o == ROW_LAST) ? '0 : row_o + ROW_W'(1);
      col_d    = col_o;
      row_d    = row_o;
      case (op_i)
         CUR_INC: begin
            if (col_o == COL_LAST) begin
               col_d = '0;
               row_d = row_next;
            end else begin
               col_d = col_o + COL_W'(1);
            end
         end
         CUR_NL: begin
            col_d = '0;
            row_d = row_next;
         end
         CUR_CR:   col_d = '0;
         CUR_DEC:  if (col_o != '0) col_d = col_o - COL_W'(1);
         CUR_HOME: begin
            col_d = '0;
            row_d = '0;
         end
         default: ;
      endcase
   end

   // Position register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         col_o <= '0;
         row_o <= '0;
      end else begin
         col_o <= col_d;
         row_o <= row_d;
      end
   end

endmodule

// File: rtl/term_ctrl.sv
// Terminal controller: turns a character stream into tile-buffer writes and
// maintains the cursor. Optional clear-screen sweep enabled by TERM_CLEAR_EN.
module term_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_TILES        = vga_pkg::H_TILES,
   parameter int unsigned V_TILES        = vga_pkg::V_TILES,
   parameter int unsigned ADDR_COL_WIDTH = vga_pkg::ADDR_COL_WIDTH,
   parameter int unsigned ADDR_ROW_WIDTH = vga_pkg::ADDR_ROW_WIDTH,
   parameter int unsigned DATA_WIDTH     = vga_pkg::DATA_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      char_valid_i,
   input  logic [DATA_WIDTH-1:0]     char_i,
   output logic                      char_ready_o,
   input  logic                      clear_i,
   output logic                      busy_o,
   output logic                      wr_en_o,
   output logic [ADDR_COL_WIDTH-1:0] col_w_o,
   output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
   output logic [DATA_WIDTH-1:0]     din_o,
   output logic [ADDR_COL_WIDTH-1:0] cur_col_o,
   output logic [ADDR_ROW_WIDTH-1:0] cur_row_o
);

   cur_op_e                   cur_op;
   logic                      char_acc;
   logic                      is_print;
   logic                      wr_en_d;
   logic [ADDR_COL_WIDTH-1:0] col_w_d;
   logic [ADDR_ROW_WIDTH-1:0] row_w_d;
   logic [DATA_WIDTH-1:0]     din_d;

   // Text cursor
   tile_cursor #(
      .COLS  (H_TILES),
      .ROWS  (V_TILES),
      .COL_W (ADDR_COL_WIDTH),
      .ROW_W (ADDR_ROW_WIDTH)
   ) u_cursor (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .op_i   (cur_op),
      .col_o  (cur_col_o),
      .row_o  (cur_row_o)
   );

`ifdef TERM_CLEAR_EN
   term_state_e               state_q;
   term_state_e               state_d;
   cur_op_e                   sweep_op;
   logic [ADDR_COL_WIDTH-1:0] sweep_col;
   logic [ADDR_ROW_WIDTH-1:0] sweep_row;
   logic                      sweep_last;

   // Sweep address; a full pass wraps it back to (0,0) ready for the next clear
   tile_cursor #(
      .COLS  (H_TILES),
      .ROWS  (V_TILES),
      .COL_W (ADDR_COL_WIDTH),
      .ROW_W (ADDR_ROW_WIDTH)
   ) u_sweep (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .op_i   (sweep_op),
      .col_o  (sweep_col),
      .row_o  (sweep_row)
   );

   assign sweep_last   = (sweep_col == ADDR_COL_WIDTH'(H_TILES - 1)) &&
                         (sweep_row == ADDR_ROW_WIDTH'(V_TILES - 1));
   assign char_ready_o = rstn_i & (state_q == IDLE) & ~clear_i;
   assign busy_o       = (state_q == CLEAR);

   // FSM state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end
`else
   logic unused_clear;

   assign unused_clear = clear_i;
   assign char_ready_o = rstn_i;
   assign busy_o       = 1'b0;
`endif

   assign char_acc = char_valid_i & char_ready_o;
   assign is_print = (char_i >= DATA_WIDTH'(CHAR_FIRST)) && (char_i <= DATA_WIDTH'(CHAR_LAST));

   // Next state, cursor operation and the write to issue on the next cycle
   always_comb begin
      wr_en_d = 1'b0;
      col_w_d = col_w_o;
      row_w_d = row_w_o;
      din_d   = din_o;
      cur_op  = CUR_HOLD;
`ifdef TERM_CLEAR_EN
      state_d  = state_q;
      sweep_op = CUR_HOLD;
      if (state_q == CLEAR) begin
         wr_en_d  = 1'b1;
         col_w_d  = sweep_col;
         row_w_d  = sweep_row;
         din_d    = DATA_WIDTH'(CHAR_NUL);
         sweep_op = CUR_INC;
         if (sweep_last) begin
            state_d = IDLE;
            cur_op  = CUR_HOME;
         end
      end else if (clear_i) begin
         state_d = CLEAR;
      end else
`endif
      if (char_acc) begin
         if (is_print) begin
            wr_en_d = 1'b1;
            col_w_d = cur_col_o;
            row_w_d = cur_row_o;
            din_d   = char_i;
            cur_op  = CUR_INC;
         end else if (char_i == DATA_WIDTH'(CHAR_LF)) begin
            cur_op = CUR_NL;
         end else if (char_i == DATA_WIDTH'(CHAR_CR)) begin
            cur_op = CUR_CR;
         end else if ((char_i == DATA_WIDTH'(CHAR_BS)) && (cur_col_o != '0)) begin
            wr_en_d = 1'b1;
            col_w_d = cur_col_o - ADDR_COL_WIDTH'(1);
            row_w_d = cur_row_o;
            din_d   = DATA_WIDTH'(CHAR_NUL);
            cur_op  = CUR_DEC;
         end
      end
   end

   // Registered tile-buffer write port
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_en_o <= 1'b0;
         col_w_o <= '0;
         row_w_o <= '0;
         din_o   <= '0;
      end else begin
         wr_en_o <= wr_en_d;
         col_w_o <= col_w_d;
         row_w_o <= row_w_d;
         din_o   <= din_d;
      end
   end

endmodule

// File: tb/tb_term_ctrl.sv
// Randomized self-checking bench for term_ctrl against a linear-position screen model.
module tb_term_ctrl;

   localparam int H = 160;
   localparam int V = 64;
   localparam int N = H * V;
`ifdef TERM_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic       clk_i;
   logic       rstn_i;
   logic       char_valid_i;
   logic [6:0] char_i;
   logic       char_ready_o;
   logic       clear_i;
   logic       busy_o;
   logic       wr_en_o;
   logic [7:0] col_w_o;
   logic [5:0] row_w_o;
   logic [6:0] din_o;
   logic [7:0] cur_col_o;
   logic [5:0] cur_row_o;

   term_ctrl dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .char_valid_i (char_valid_i),
      .char_i       (char_i),
      .char_ready_o (char_ready_o),
      .clear_i      (clear_i),
      .busy_o       (busy_o),
      .wr_en_o      (wr_en_o),
      .col_w_o      (col_w_o),
      .row_w_o      (row_w_o),
      .din_o        (din_o),
      .cur_col_o    (cur_col_o),
      .cur_row_o    (cur_row_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_vec;
   int n_err;

   // Model: cursor as a linear tile index, remaining clear-sweep cycles
   int pos;
   int clr_left;
   bit exp_wr;
   int exp_col;
   int exp_row;
   int exp_din;
   int wr_seen;
   int busy_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_char(input int code);
      if (code >= 32 && code <= 126) begin
         exp_wr  = 1'b1;
         exp_col = pos % H;
         exp_row = pos / H;
         exp_din = code;
         pos     = (pos + 1) % N;
      end else if (code == 10) begin
         pos = ((pos / H + 1) % V) * H;
      end else if (code == 13) begin
         pos = (pos / H) * H;
      end else if (code == 8 && (pos % H) != 0) begin
         pos     = pos - 1;
         exp_wr  = 1'b1;
         exp_col = pos % H;
         exp_row = pos / H;
         exp_din = 0;
      end
   endtask

   // One clock cycle: drive on the falling edge, check after the rising edge
   task automatic step(input bit v, input int code, input bit clr);
      bit exp_ready;
      @(negedge clk_i);
      char_valid_i = v;
      char_i       = 7'(code);
      clear_i      = clr;
      #1;
      exp_ready = !CLR_EN || (clr_left == 0 && !clr);
      check_eq("ready", char_ready_o, exp_ready);
      exp_wr = 1'b0;
      if (CLR_EN && clr_left > 0) begin
         exp_wr  = 1'b1;
         exp_col = (N - clr_left) % H;
         exp_row = (N - clr_left) / H;
         exp_din = 0;
         clr_left--;
         if (clr_left == 0) pos = 0;
      end else if (CLR_EN && clr) begin
         clr_left = N;
      end else if (v && exp_ready) begin
         model_char(code);
      end
      @(posedge clk_i);
      #1;
      check_eq("wr_en", wr_en_o, exp_wr);
      if (exp_wr) begin
         check_eq("col_w", col_w_o, exp_col);
         check_eq("row_w", row_w_o, exp_row);
         check_eq("din", din_o, exp_din);
      end
      check_eq("cur_col", cur_col_o, pos % H);
      check_eq("cur_row", cur_row_o, pos / H);
      check_eq("busy", busy_o, clr_left > 0);
      if (wr_en_o) wr_seen++;
      if (busy_o) busy_seen++;
   endtask

   // Assert reset immediately, verify cleared outputs, release on a falling edge
   task automatic apply_reset();
      char_valid_i = 1'b0;
      clear_i      = 1'b0;
      rstn_i       = 1'b0;
      #1;
      check_eq("rst_wr_en", wr_en_o, 0);
      check_eq("rst_col_w", col_w_o, 0);
      check_eq("rst_row_w", row_w_o, 0);
      check_eq("rst_din", din_o, 0);
      check_eq("rst_cur_col", cur_col_o, 0);
      check_eq("rst_cur_row", cur_row_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_ready", char_ready_o, 0);
      pos      = 0;
      clr_left = 0;
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   function automatic int rand_code();
      case ($urandom % 8)
         0, 1, 2, 3: return 32 + int'($urandom % 95);
         4:          return 10;
         5:          return 13;
         6:          return 8;
         default:    return int'($urandom % 128);
      endcase
   endfunction

   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sweeps;
      n_vec = 0; n_err = 0; pos = 0; clr_left = 0;
      wr_seen = 0; busy_seen = 0; sweeps = 0;
      rstn_i = 1'b0; char_valid_i = 1'b0; char_i = '0; clear_i = 1'b0;
      #3;
      apply_reset();

      // Single printable character at home
      step(1, 'h41, 0);
      check_eq("a_wr", wr_en_o, 1);
      check_eq("a_din", din_o, 'h41);
      check_eq("a_col", col_w_o, 0);
      check_eq("a_row", row_w_o, 0);
      check_eq("a_cur_col", cur_col_o, 1);
      check_eq("a_cur_row", cur_row_o, 0);

      // Line wrap after a full row
      apply_reset();
      for (int i = 0; i < 161; i++) step(1, 32 + (i % 95), 0);
      check_eq("wrap_col_w", col_w_o, 0);
      check_eq("wrap_row_w", row_w_o, 1);
      check_eq("wrap_cur_col", cur_col_o, 1);
      check_eq("wrap_cur_row", cur_row_o, 1);

      // LF on the last row wraps to the top; BS at column 0 does nothing
      apply_reset();
      for (int i = 0; i < 63; i++) step(1, 10, 0);
      for (int i = 0; i < 5; i++) step(1, 'h78, 0);
      check_eq("pre_lf_col", cur_col_o, 5);
      check_eq("pre_lf_row", cur_row_o, 63);
      step(1, 10, 0);
      check_eq("lf_wr", wr_en_o, 0);
      check_eq("lf_col", cur_col_o, 0);
      check_eq("lf_row", cur_row_o, 0);
      step(1, 8, 0);
      check_eq("bs0_wr", wr_en_o, 0);
      check_eq("bs0_col", cur_col_o, 0);
      for (int i = 0; i < 3; i++) step(1, 'h79, 0);
      step(1, 8, 0);
      check_eq("bs_wr", wr_en_o, 1);
      check_eq("bs_din", din_o, 0);
      check_eq("bs_col_w", col_w_o, 2);
      check_eq("bs_cur", cur_col_o, 2);

`ifdef TERM_CLEAR_EN
      // Clear beats a simultaneous character, which stays pending
      apply_reset();
      step(1, 'h41, 0);
      wr_seen = 0; busy_seen = 0;
      step(1, 'h5A, 1);
      for (int i = 0; i < N; i++) step(1, 'h5A, i == 3000);
      check_eq("clr_writes", wr_seen, N);
      check_eq("clr_busy_cycles", busy_seen, N);
      check_eq("clr_cur_col", cur_col_o, 0);
      check_eq("clr_cur_row", cur_row_o, 0);
      step(1, 'h5A, 0);
      check_eq("pend_wr", wr_en_o, 1);
      check_eq("pend_din", din_o, 'h5A);
      check_eq("pend_col", col_w_o, 0);

      // Reset part-way through a sweep
      apply_reset();
      step(0, 0, 1);
      wr_seen = 0;
      for (int i = 0; i < N && wr_seen < 500; i++) step(0, 0, 0);
      check_eq("sweep500", wr_seen, 500);
      #2;
      apply_reset();
      wr_seen = 0;
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      check_eq("post_rst_writes", wr_seen, 0);
      check_eq("post_rst_ready", char_ready_o, 1);
`else
      // Clear request is ignored
      apply_reset();
      wr_seen = 0; busy_seen = 0;
      step(0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      check_eq("noclr_writes", wr_seen, 0);
      check_eq("noclr_busy", busy_seen, 0);
`endif

      // Random traffic
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         bit v;
         bit c;
         v = ($urandom % 4) != 0;
         c = (sweeps < 2) && (($urandom % 300) == 0);
         if (c) sweeps++;
         step(v, rand_code(), c);
      end
      while (clr_left > 0) step(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_TILES, 160, tile columns.
- V_TILES, 64, tile rows.
- ADDR_COL_WIDTH, 8, column index width.
- ADDR_ROW_WIDTH, 6, row index width.
- DATA_WIDTH, 7, character code width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, single 108 MHz clock.
- rstn_i, in, 1, reset; asynchronous, active-low.
- char_valid_i, in, 1, character offered.
- char_i, in, DATA_WIDTH, ASCII code.
- char_ready_o, out, 1, character accepted when high with char_valid_i.
- clear_i, in, 1, clear-screen request pulse.
- busy_o, out, 1, clear sweep in progress.
- wr_en_o, out, 1, tile buffer write enable.
- col_w_o, out, ADDR_COL_WIDTH, tile buffer write column.
- row_w_o, out, ADDR_ROW_WIDTH, tile buffer write row.
- din_o, out, DATA_WIDTH, tile buffer write data.
- cur_col_o, out, ADDR_COL_WIDTH, cursor column.
- cur_row_o, out, ADDR_ROW_WIDTH, cursor row.

Function
REQ-003 The FSM SHALL have states IDLE and CLEAR; it SHALL accept characters only in IDLE.
REQ-004 char_ready_o SHALL equal (state==IDLE) AND NOT clear_i; a character is accepted when char_valid_i AND char_ready_o.
REQ-005 An accepted printable code (0x20..0x7E) SHALL produce exactly one write on the next cycle:
- wr_en_o=1, din_o=code, col_w_o/row_w_o = cursor at acceptance.
- The cursor SHALL advance one column in the same cycle as that write.
REQ-006 Column advance from H_TILES-1 SHALL wrap to column 0, row+1. Row advance from V_TILES-1 SHALL wrap to row 0 (no scrolling).
REQ-007 LF (0x0A) SHALL set column to 0 and advance the row with wrap. CR (0x0D) SHALL set column to 0. Neither SHALL write.
REQ-008 BS (0x08) at column>0 SHALL:
- decrement the column;
- write 0x00 at (column-1, row) on the next cycle.
BS at column 0 SHALL be a no-op.
REQ-009 All other codes (0x00..0x1F except the three above, and 0x7F) SHALL be consumed with no write and no cursor change.
REQ-010 Throughput SHALL be one character per cycle in IDLE; wr_en_o SHALL be high for exactly one cycle per writing character.
REQ-011 clear_i high in IDLE SHALL enter CLEAR on the next edge. If char_valid_i is high in the same cycle, clear wins and the character stays pending.
REQ-012 In CLEAR the block SHALL:
- write 0x00 to every tile in row-major order, one per cycle, starting at (0,0), for H_TILES*V_TILES cycles;
- hold busy_o=1 and char_ready_o=0;
- then set the cursor to (0,0), clear busy_o, and return to IDLE.
REQ-013 clear_i asserted during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-014 Write-address arithmetic SHALL stay within the declared widths; no address beyond H_TILES-1 or V_TILES-1 SHALL be emitted.

Reset
REQ-015 While rstn_i is low:
- state=IDLE;
- wr_en_o=0, col_w_o=0, row_w_o=0, din_o=0;
- cur_col_o=0, cur_row_o=0, busy_o=0;
- char_ready_o=0.
REQ-016 Reset asserted mid-sweep SHALL abort CLEAR immediately. Tiles already cleared stay cleared; no write occurs after reset release without new stimulus.

Configuration
REQ-017 With TERM_CLEAR_EN defined, clear behaviour SHALL be as in REQ-011..013.
REQ-018 Without TERM_CLEAR_EN:
- clear_i SHALL be ignored;
- the CLEAR state and sweep counter SHALL not exist;
- busy_o SHALL be tied 0;
- char_ready_o SHALL be 1 whenever out of reset.

Structure
REQ-019 Package vga_pkg SHALL hold:
- H_TILES, V_TILES and the address and data widths;
- the character constants CHAR_LF, CHAR_CR, CHAR_BS, CHAR_NUL;
- the FSM state typedef.
REQ-020 The cursor counters with their wrap logic SHALL be one sub-module, tile_cursor. It SHALL support increment, newline, carriage return and decrement, and SHALL be reused for the sweep address.

Verification
REQ-021 Reset, then 'A' (0x41) at cursor (0,0) -> next cycle wr_en_o=1, din_o=0x41, col 0/row 0; cursor becomes (1,0).
REQ-022 161 printable characters from (0,0) -> character 160 written at (0,1); cursor ends at (1,1).
REQ-023 Cursor at (5,63), send LF -> cursor (0,0), no write. Send BS at (0,0) -> no write, cursor unchanged.
REQ-024 clear_i and char_valid_i high in the same cycle -> char not accepted; exactly 10240 writes of 0x00, row-major; busy_o high for 10240 cycles; cursor (0,0); pending char then accepted.
REQ-025 rstn_i low at sweep write 500 -> outputs zero immediately; after release no writes, state IDLE, char_ready_o=1.
REQ-026 Build without TERM_CLEAR_EN, pulse clear_i -> no writes, busy_o=0.
